// File: rtl/mac_fp_result_drain_if.sv
// mac_fp_result_drain_if
//   Bundles the signals between the FP add column, the result drain and the
//   writeback consumer.
//   slave  modport : the drain itself (consumes in_*, produces out_*, stall).
//   master modport : the surrounding logic (column pipeline + consumer).
//   in_data/in_valid/in_col/in_done : vector from the adder column.
//   stall                           : freeze request back to the column.
//   out_data/out_valid/out_ready    : serialized 32-bit word stream.
//   out_lane/out_col/out_last       : word position tags.
//   done_pulse                      : job-complete pulse.
//   level                           : vectors currently buffered.
interface mac_fp_result_drain_if #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(SIZE),
    parameter int LW    = $clog2(DEPTH + 1)
);
    logic [SIZE*32-1:0] in_data;
    logic               in_valid;
    logic [CW-1:0]      in_col;
    logic               in_done;
    logic               stall;
    logic [31:0]        out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      out_lane;
    logic [CW-1:0]      out_col;
    logic               out_last;
    logic               done_pulse;
    logic [LW-1:0]      level;

    modport slave (
        input  in_data, in_valid, in_col, in_done, out_ready,
        output stall, out_data, out_valid, out_lane, out_col, out_last,
               done_pulse, level
    );

    modport master (
        output in_data, in_valid, in_col, in_done, out_ready,
        input  stall, out_data, out_valid, out_lane, out_col, out_last,
               done_pulse, level
    );
endinterface

// File: rtl/mac_fp_result_drain.sv
// mac_fp_result_drain
//   Buffers SIZE x 32-bit result vectors from the FP add column in a DEPTH-deep
//   FIFO and serializes each vector, lane 0 first, onto a 32-bit valid/ready
//   stream. Raises stall while the FIFO is full so the column freezes.
//   clk  : clock, rising edge.
//   rst  : asynchronous active-high reset; discards all buffered vectors.
//   bus  : mac_fp_result_drain_if.slave (column input, word output, status).
module mac_fp_result_drain #(
    parameter int SIZE  = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(SIZE)
) (
    input logic                   clk,
    input logic                   rst,
    mac_fp_result_drain_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [SIZE*32-1:0] r_mem_data [DEPTH];
    logic [CW-1:0]      r_mem_col  [DEPTH];
    logic               r_mem_done [DEPTH];

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;

    state_t             r_state;
    logic [CW-1:0]      r_word;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic [CW-1:0]      r_out_col;
    logic               r_out_last;
    logic               r_cur_done;
    logic               r_done_pulse;

    logic               w_stall;
    logic               w_push;
    logic               w_hs;
    logic               w_pop;
    logic [PW-1:0]      w_rd_next;

    function automatic logic [31:0] f_lane(input logic [SIZE*32-1:0] v,
                                           input logic [CW-1:0] idx);
        return v[32*int'(idx) +: 32];
    endfunction

    // Stall depends only on registered level, so there is no ready->stall path.
    assign w_stall   = (r_level == LW'(DEPTH));
    assign w_push    = bus.in_valid & ~w_stall;
    assign w_hs      = r_out_valid & bus.out_ready;
    assign w_pop     = w_hs & r_out_last;
    assign w_rd_next = r_rd_ptr + PW'(1);

    assign bus.stall      = w_stall;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_lane   = r_word;
    assign bus.out_col    = r_out_col;
    assign bus.out_last   = r_out_last;
    assign bus.done_pulse = r_done_pulse;
    assign bus.level      = r_level;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.in_data;
            r_mem_col[r_wr_ptr]  <= bus.in_col;
            r_mem_done[r_wr_ptr] <= bus.in_done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_next;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Serializer FSM. Outputs are registered, so the next head vector is
    // loaded one step ahead; when the FIFO would otherwise be empty after a
    // pop, the vector being pushed that same cycle is taken straight from
    // the input to avoid a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_col    <= '0;
            r_out_last   <= 1'b0;
            r_cur_done   <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_level != '0) begin
                        r_state     <= SEND;
                        r_out_valid <= 1'b1;
                        r_word      <= '0;
                        r_out_data  <= f_lane(r_mem_data[r_rd_ptr], '0);
                        r_out_col   <= r_mem_col[r_rd_ptr];
                        r_cur_done  <= r_mem_done[r_rd_ptr];
                        r_out_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (!r_out_last) begin
                            r_word     <= r_word + CW'(1);
                            r_out_data <= f_lane(r_mem_data[r_rd_ptr], r_word + CW'(1));
                            r_out_last <= ((r_word + CW'(1)) == CW'(SIZE - 1));
                        end else begin
                            r_done_pulse <= r_cur_done;
                            r_word       <= '0;
                            r_out_last   <= 1'b0;
                            if (r_level > LW'(1)) begin
                                r_out_data <= f_lane(r_mem_data[w_rd_next], '0);
                                r_out_col  <= r_mem_col[w_rd_next];
                                r_cur_done <= r_mem_done[w_rd_next];
                            end else if (w_push) begin
                                r_out_data <= f_lane(bus.in_data, '0);
                                r_out_col  <= bus.in_col;
                                r_cur_done <= bus.in_done;
                            end else begin
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_fp_result_drain.sv
module tb_mac_fp_result_drain;
    localparam int SIZE  = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(SIZE);

    typedef struct {
        logic [31:0]   data;
        logic [CW-1:0] lane;
        logic [CW-1:0] col;
        logic          last;
        logic          done;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   ready_mode;
    int   cyc;
    exp_t sb[$];

    mac_fp_result_drain_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    mac_fp_result_drain #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Ready pattern generator: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = never.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Drive one vector and hold it until captured; expected words are queued
    // at the capture point. Called just after a rising edge, returns just
    // after the capturing edge.
    task automatic push_vec(input logic [CW-1:0] col, input logic done, input logic [31:0] base);
        int   n;
        exp_t e;
        for (int i = 0; i < SIZE; i++) bus.in_data[i*32 +: 32] = base + 32'(i);
        bus.in_col   = col;
        bus.in_done  = done;
        bus.in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            if (n > 2000) begin
                check("push_timeout", 64'(n), 64'(0));
                bus.in_valid = 1'b0;
                return;
            end
        end
        for (int i = 0; i < SIZE; i++) begin
            e.data = base + 32'(i);
            e.lane = CW'(i);
            e.col  = col;
            e.last = (i == SIZE - 1);
            e.done = done;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 || bus.out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                check("drain_timeout", 64'(sb.size()), 64'(0));
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: compares each accepted word with the scoreboard head,
    // checks hold stability under backpressure and the done pulse timing.
    logic        exp_dp;
    logic        hold_prev;
    logic [31:0] hold_data;
    logic [CW-1:0] hold_lane;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_dp    = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (exp_dp || bus.done_pulse) check("done_pulse", 64'(bus.done_pulse), 64'(exp_dp));
            exp_dp = 1'b0;
            if (hold_prev) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_data", {bus.out_lane, bus.out_data}, {hold_lane, hold_data});
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_lane = bus.out_lane;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {bus.out_col, bus.out_lane, bus.out_data}, 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("word", {bus.out_col, bus.out_lane, bus.out_last, bus.out_data},
                          {e.col, e.lane, e.last, e.data});
                    if (e.last && e.done) exp_dp = 1'b1;
                end
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        ready_mode = 0;
        rst = 1'b1;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_col = '0;
        bus.in_done = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_level", 64'(bus.level), 64'(0));
        check("rst_data", {bus.out_lane, bus.out_col, bus.out_last, bus.done_pulse, bus.out_data}, 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single vector, done flagged; first word one cycle after capture
        push_vec(4'd5, 1'b1, 32'h3F800000);
        check("lat_idle", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_send", 64'(bus.out_valid), 64'(1));
        wait_drain();

        // Backpressure pattern
        ready_mode = 1;
        push_vec(4'd7, 1'b0, 32'h40000000);
        wait_drain();
        ready_mode = 0;

        // Full / stall: 5th vector must wait and be captured exactly once
        ready_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_vec(CW'(i), 1'b0, 32'h10000000 * (i + 1));
        check("full_level", 64'(bus.level), 64'(DEPTH));
        check("full_stall", 64'(bus.stall), 64'(1));
        fork
            push_vec(4'd4, 1'b1, 32'h50000000);
            begin
                repeat (10) @(posedge clk);
                #2;
                check("held_level", 64'(bus.level), 64'(DEPTH));
                check("held_sb", 64'(sb.size()), 64'(4 * SIZE));
                ready_mode = 0;
            end
        join
        wait_drain();

        // Simultaneous push and pop at level 1
        push_vec(4'd9, 1'b0, 32'h60000000);
        repeat (16) @(posedge clk);
        #1;
        push_vec(4'd10, 1'b0, 32'h70000000);
        @(negedge clk);
        check("simul_level", 64'(bus.level), 64'(1));
        check("simul_next", {bus.out_valid, bus.out_col, bus.out_lane}, {1'b1, 4'd10, 4'd0});
        wait_drain();

        // Pointer wrap over 10 back-to-back vectors
        for (int i = 0; i < 10; i++) push_vec(CW'(i + 3), (i % 3) == 0, 32'hA0000000 + 32'(i << 8));
        wait_drain();

        // Reset mid-transfer with two vectors buffered
        ready_mode = 2;
        @(posedge clk);
        #1;
        push_vec(4'd1, 1'b1, 32'hB0000000);
        push_vec(4'd2, 1'b1, 32'hC0000000);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_level", 64'(bus.level), 64'(2));
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_stall", 64'(bus.stall), 64'(0));
        check("mid_rst_level", 64'(bus.level), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_level", 64'(bus.level), 64'(0));
        check("post_rst_valid", 64'(bus.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_fp_result_drain.md
Name: mac_fp_result_drain

Overview:
- Sits downstream of the MAC floating-point add column and consumes its per-cycle output vectors: SIZE x 32-bit sums, each tagged with a valid bit, a B-column index and a done flag.
- Buffers whole vectors in a small FIFO.
- Serializes each vector into 32-bit words on a valid/ready stream toward the result writeback / bus master.
- Drives the accelerator-wide stall back into the column pipeline when the FIFO cannot accept another vector.

Parameters:
- SIZE, 16, lanes per vector; power of two, >= 2.
- DEPTH, 4, FIFO depth in vectors; power of two, >= 2.
- CW, $clog2(SIZE), width of column index and word index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  SIZE*32  adder column sums; lane i occupies bits [i*32 +: 32].
- in_valid  input  1  pipeline valid from the column.
- in_col  input  CW  B-column index of the vector.
- in_done  input  1  vector is the last of the job.
- stall  output  1  freeze request to the column pipeline and upstream.
- out_data  output  32  current serialized word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word.
- out_lane  output  CW  lane index of out_data (row within the column).
- out_col  output  CW  B-column index of the vector being sent.
- out_last  output  1  word is lane SIZE-1 of its vector.
- done_pulse  output  1  one-cycle pulse after the final word of a done-flagged vector is accepted.
- level  output  $clog2(DEPTH+1)  vectors currently held.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers, level and word counter go to 0; FSM goes to IDLE.
  - stall=0, out_valid=0, out_data=0, out_lane=0, out_col=0, out_last=0, done_pulse=0.
  - Reset mid-transfer discards all buffered vectors. There is no partial-vector recovery.
- stall:
  - Combinational: stall = (level == DEPTH).
  - Asserting it freezes the column, so in_valid/in_col/in_done/in_data stay held until stall drops.
- Push:
  - Push occurs when in_valid & ~stall.
  - Writes {in_done, in_col, in_data} at the write pointer and increments the write pointer, wrapping modulo DEPTH.
  - in_valid while stall=1 is ignored. The held vector is captured on the first cycle stall=0, exactly once.
- Pop:
  - Pop occurs on the handshake of the word with out_last=1 (out_valid & out_ready & out_last).
  - Increments the read pointer, wrapping modulo DEPTH.
- Level:
  - level += push - pop. Simultaneous push and pop leaves level unchanged.
  - No push when level==DEPTH, even if a pop happens the same cycle; stall is registered-state based, so there is no combinational ready path.
- FSM:
  - IDLE: out_valid=0. Go to SEND when level != 0; word counter = 0.
  - SEND:
    - out_valid=1.
    - out_data = head vector lane[word]; out_lane = word.
    - out_col = head col; out_last = (word == SIZE-1).
  - Handshake with word < SIZE-1: word <= word+1.
  - Handshake with word == SIZE-1:
    - Pop the vector; word <= 0.
    - Stay in SEND if level after the pop is nonzero; this includes a vector pushed the same cycle. Otherwise go to IDLE.
  - out_ready=0 holds all out_* stable; out_valid never deasserts without a handshake.
- Output latency:
  - A vector pushed into an empty FIFO at edge N gives out_valid=1 after edge N+1, i.e. the IDLE->SEND transition.
  - Steady state with out_ready=1 is 1 word/cycle. A vector drains in SIZE cycles with no bubble between back-to-back vectors.
- done_pulse:
  - Registered; high the cycle after the last word of a vector with done=1 is accepted.
  - Independent of stall and of subsequent traffic.
- Data:
  - Words are passed bit-exact; no FP interpretation.
  - Lanes are sent in ascending order 0..SIZE-1.

Test Plan:
- Reset and idle: rst pulse mid-SEND with level=2 -> same cycle out_valid=0, stall=0, level=0; after release no words emerge.
- Single vector: SIZE=16, push lanes i=0x3F800000+i, col=5, done=1, out_ready=1 -> 16 words, out_lane 0..15, out_col=5, out_last only on lane 15, done_pulse one cycle later.
- Backpressure: out_ready toggles 1,0,0,1 per cycle -> each word held stable while ready=0, no word dropped or duplicated, final order 0..15.
- Full/stall: out_ready=0, push 4 vectors (cols 0..3) -> level=4, stall=1. A 5th vector held on in_* while stall=1 is not captured. Then out_ready=1 -> after the first vector drains, stall drops, the 5th vector is captured exactly once, and the stream shows cols 0,1,2,3,4.
- Simultaneous push/pop: level=1, push on the same cycle as the out_last handshake -> level stays 1, the next vector starts next cycle with no bubble.
- Pointer wrap: stream 10 vectors with out_ready=1 -> cols and data emerge in push order across FIFO wrap, done_pulse only for done-flagged vectors.
